pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline control for the 5-stage CPU.
- Collects stall requests from the PC/IF, ID, EX and MEM stages and exception/ERET redirects from MEM/CP0.
- Drives the 2-bit `stall_module_bus` vector into every inter-stage register, plus the global `flush` and redirect PC.
- It is the producing end of the stall/flush interface that all stage registers consume.

Parameters:
- STALL_TIMEOUT, 1023, consecutive stalled cycles before the sticky `stall_timeout` is raised.
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- `clk` input 1: system clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `stallreq_if` input 1: fetch stage requests hold (icache miss).
- `stallreq_id` input 1: decode requests hold (load-use hazard).
- `stallreq_ex` input 1: execute requests hold (mul/div busy).
- `stallreq_mem` input 1: memory stage requests hold (dcache/uncached access outstanding).
- `excp_valid` input 1: exception or ERET committed in MEM, single-cycle pulse.
- `excp_target` input 32: handler address or EPC accompanying `excp_valid`.
- `stall_pc_if` output 2: stall vector for the PC→IF register.
- `stall_if_id` output 2: stall vector for the IF→ID register.
- `stall_id_ex` output 2: stall vector for the ID→EX register.
- `stall_ex_mem` output 2: stall vector for the EX→MEM register.
- `stall_mem_wb` output 2: stall vector for the MEM→WB register.
- `flush` output 1: clear all stage registers.
- `new_pc_valid` output 1: PC register loads `new_pc`.
- `new_pc` output 32: redirect address.
- `stall_timeout` output 1: sticky watchdog flag.
- `stall_cycles` output CNT_W: saturating count of stalled cycles.

Behaviour:
- **Reset.** On async reset all outputs are 0: vectors 2'b00, `flush`, `new_pc_valid`, `new_pc`, `stall_timeout`, `stall_cycles`. State is IDLE and the target register is 0.
- **Internal hold vector.** `h[5:0]` covers stages PC, IF, ID, EX, MEM, WB. A request from stage s sets `h[0..s]`. WB is never held: `h[5]` = 0.
- **Boundary vector.** The vector for the boundary between stage i and stage i+1 is `{h[i], h[i+1]}`.
  - 2'b11 or 2'b00: hold or advance.
  - 2'b10: bubble into the downstream register.
  - 2'b01 never occurs.
- **Combinational stall path.** Vectors are combinational from `stallreq_*` in the same cycle. When `flush` = 1 all vectors are forced to 2'b00.
- **FSM states:**
  - IDLE: normal operation.
  - WAIT_MEM: exception latched, waiting for the MEM access to finish.
  - FLUSH: one cycle, `flush` = `new_pc_valid` = 1.
- **FSM transitions:**
  - IDLE & `excp_valid` & !`stallreq_mem` → FLUSH; `excp_target` is captured into the target register.
  - IDLE & `excp_valid` & `stallreq_mem` → WAIT_MEM; target captured. Stall vectors continue to follow the requests.
  - WAIT_MEM & !`stallreq_mem` → FLUSH.
  - WAIT_MEM & `excp_valid`: ignored; the first captured target wins.
  - FLUSH → IDLE unconditionally. `excp_valid` arriving in FLUSH is ignored.
- **Redirect outputs.** `flush` and `new_pc_valid` are registered: they are high exactly one cycle, the cycle after the accepting edge. `new_pc` equals the target register and holds its value afterwards.
- **Exception latency.** From `excp_valid` sampled with MEM idle to `flush` high is 1 cycle.
- **Watchdog.** An internal counter increments every cycle `h[0]` = 1 and clears on any cycle `h[0]` = 0 or `flush` = 1. When it reaches STALL_TIMEOUT, `stall_timeout` sets and stays set until reset.
- **Performance counter.** `stall_cycles` increments on every cycle with `h[0]` = 1 and `flush` = 0. It saturates at all-ones and does not wrap.
- **Reset mid-operation.** Asserting `resetn` low in WAIT_MEM or FLUSH returns immediately to IDLE with all outputs 0. The captured target is discarded.

Test Plan:
- **Reset:** hold `resetn` = 0 with all requests = 1 → all vectors 00, `flush` 0, `stall_cycles` 0; release and verify the counter starts.
- **Decode stall:** `stallreq_id` = 1, 3 cycles:
  - `stall_pc_if` = 11, `stall_if_id` = 11, `stall_id_ex` = 10, `stall_ex_mem` = 00, `stall_mem_wb` = 00;
  - `stall_cycles` = 3 after drop.
- **Memory stall:** `stallreq_mem` = 1 → vectors 11, 11, 11, 11, 10.
- **Exception with MEM idle:** `excp_valid` with `excp_target` = 0xBFC00380 at cycle N:
  - `flush` = `new_pc_valid` = 1 only in cycle N+1, `new_pc` = 0xBFC00380;
  - all vectors 00 in N+1 even with `stallreq_ex` = 1.
- **Exception during MEM stall:** `excp_valid` (target 0x80000180) while `stallreq_mem` = 1 for 4 more cycles, plus a second `excp_valid` (0x1234) 2 cycles later:
  - `flush` the cycle after `stallreq_mem` falls;
  - `new_pc` = 0x80000180.
- **Watchdog:** STALL_TIMEOUT = 8, `stallreq_if` held 8 cycles → `stall_timeout` rises at the 8th and stays high after the request drops; async reset clears it.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Central stall/flush control for the 5-stage pipeline: per-boundary
//            stall vectors, exception redirect, stall watchdog and counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int STALL_TIMEOUT = 1023,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_target,
    output logic [1:0]       stall_pc_if,
    output logic [1:0]       stall_if_id,
    output logic [1:0]       stall_id_ex,
    output logic [1:0]       stall_ex_mem,
    output logic [1:0]       stall_mem_wb,
    output logic             flush,
    output logic             new_pc_valid,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       target_q, target_d;
    logic              flush_q, flush_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [5:0]        h;
    logic              vec_en;
    logic              stalled;

    // A request from a stage holds that stage and everything upstream of it.
    always_comb begin
        h    = 6'b000000;
        h[4] = stallreq_mem;
        h[3] = stallreq_mem | stallreq_ex;
        h[2] = stallreq_mem | stallreq_ex | stallreq_id;
        h[1] = stallreq_mem | stallreq_ex | stallreq_id | stallreq_if;
        h[0] = h[1];
    end

    // Vectors read zero while in reset so stage registers see a clean state.
    assign vec_en = resetn & ~flush_q;

    always_comb begin
        stall_pc_if  = 2'b00;
        stall_if_id  = 2'b00;
        stall_id_ex  = 2'b00;
        stall_ex_mem = 2'b00;
        stall_mem_wb = 2'b00;
        if (vec_en) begin
            stall_pc_if  = {h[0], h[1]};
            stall_if_id  = {h[1], h[2]};
            stall_id_ex  = {h[2], h[3]};
            stall_ex_mem = {h[3], h[4]};
            stall_mem_wb = {h[4], h[5]};
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        flush_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (excp_valid) begin
                    target_d = excp_target;
                    if (stallreq_mem) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d = FLUSH;
                        flush_d = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (!stallreq_mem) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Cycles spent flushing are neither counted nor part of a stall run.
    assign stalled = h[0] & ~flush_q;

    always_comb begin
        wd_d = '0;
        if (stalled) begin
            wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + WD_W'(1);
        end
        timeout_d = timeout_q | (wd_d == WD_LIMIT);
        cnt_d     = cnt_q;
        if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            target_q  <= 32'h0;
            flush_q   <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            flush_q   <= flush_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign flush         = flush_q;
    assign new_pc_valid  = flush_q;
    assign new_pc        = target_q;
    assign stall_timeout = timeout_q;
    assign stall_cycles  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Directed plus random stimulus against an event-level model of
//            the stall/flush controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int T_OUT = 8;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          stallreq_if = 1'b0, stallreq_id = 1'b0;
    logic          stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic          excp_valid = 1'b0;
    logic [31:0]   excp_target = 32'h0;
    logic [1:0]    stall_pc_if, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic          flush, new_pc_valid, stall_timeout;
    logic [31:0]   new_pc;
    logic [CW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: redirect due next cycle, pending exception, target, counters.
    logic        m_flush, m_pend, m_to;
    logic [31:0] m_tgt;
    int          m_cnt, m_run;

    pipe_stall_ctrl #(.STALL_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_target(excp_target),
        .stall_pc_if(stall_pc_if), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .stall_mem_wb(stall_mem_wb), .flush(flush),
        .new_pc_valid(new_pc_valid), .new_pc(new_pc),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Deepest requesting stage: PC=0, IF=1, ID=2, EX=3, MEM=4; -1 when none.
    function automatic int deepest();
        if (stallreq_mem) return 4;
        if (stallreq_ex)  return 3;
        if (stallreq_id)  return 2;
        if (stallreq_if)  return 1;
        return -1;
    endfunction

    function automatic logic [1:0] exp_vec(input int b);
        int s;
        s = deepest();
        if (!resetn || m_flush) return 2'b00;
        return {(b <= s), ((b + 1) <= s)};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pc_if"},  {30'd0, stall_pc_if},  {30'd0, exp_vec(0)});
        check({tag, ".if_id"},  {30'd0, stall_if_id},  {30'd0, exp_vec(1)});
        check({tag, ".id_ex"},  {30'd0, stall_id_ex},  {30'd0, exp_vec(2)});
        check({tag, ".ex_mem"}, {30'd0, stall_ex_mem}, {30'd0, exp_vec(3)});
        check({tag, ".mem_wb"}, {30'd0, stall_mem_wb}, {30'd0, exp_vec(4)});
        check({tag, ".flush"},  {31'd0, flush},        {31'd0, m_flush});
        check({tag, ".npv"},    {31'd0, new_pc_valid}, {31'd0, m_flush});
        check({tag, ".new_pc"}, new_pc,                m_tgt);
        check({tag, ".tmo"},    {31'd0, stall_timeout}, {31'd0, m_to});
        check({tag, ".cnt"},    {24'd0, stall_cycles}, 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_flush = 1'b0; m_pend = 1'b0; m_to = 1'b0;
        m_tgt = 32'h0; m_cnt = 0; m_run = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic was_flush, nxt;
        was_flush = m_flush;
        nxt = 1'b0;
        if (deepest() >= 0 && !was_flush) begin
            m_run++;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
            m_run = 0;
        end
        if (m_run >= T_OUT) m_to = 1'b1;
        if (!was_flush) begin
            if (m_pend) begin
                if (!stallreq_mem) begin
                    m_pend = 1'b0;
                    nxt = 1'b1;
                end
            end else if (excp_valid) begin
                m_tgt = excp_target;
                if (stallreq_mem) m_pend = 1'b1;
                else nxt = 1'b1;
            end
        end
        m_flush = nxt;
    endtask

    // One cycle: drive inputs just after an edge, check mid-cycle, clock the model.
    task automatic cyc(input logic [3:0] req, input logic ev, input logic [31:0] tgt);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excp_valid  = ev;
        excp_target = tgt;
        #2;
        check_all("cyc");
        @(posedge clk);
        model_edge();
        #1;
        excp_valid = 1'b0;
    endtask

    // Asynchronous reset with every request high; ends aligned just after an edge.
    task automatic do_reset();
        resetn = 1'b0;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'hF;
        excp_valid = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'h0;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        cyc(4'b0001, 1'b0, 32'h0);
        cyc(4'b0001, 1'b0, 32'h0);
        check("cnt_starts", {24'd0, stall_cycles}, 32'd2);

        do_reset();
        repeat (3) cyc(4'b0010, 1'b0, 32'h0);
        cyc(4'b0000, 1'b0, 32'h0);
        check("id_stall_cnt", {24'd0, stall_cycles}, 32'd3);

        repeat (2) cyc(4'b1000, 1'b0, 32'h0);

        cyc(4'b0000, 1'b1, 32'hBFC00380);
        cyc(4'b0100, 1'b0, 32'h0);
        check("excp_idle_pc", new_pc, 32'hBFC00380);
        cyc(4'b0000, 1'b0, 32'h0);

        cyc(4'b1000, 1'b1, 32'h80000180);
        cyc(4'b1000, 1'b0, 32'h0);
        cyc(4'b1000, 1'b1, 32'h00001234);
        cyc(4'b1000, 1'b0, 32'h0);
        cyc(4'b1000, 1'b0, 32'h0);
        cyc(4'b0000, 1'b0, 32'h0);
        check("excp_mem_flush", {31'd0, flush}, 32'd1);
        check("excp_mem_pc", new_pc, 32'h80000180);
        cyc(4'b0000, 1'b0, 32'h0);

        // Back-to-back exceptions: the one arriving during the flush is dropped.
        cyc(4'b0000, 1'b1, 32'hA0000000);
        cyc(4'b0000, 1'b1, 32'hB0000000);
        cyc(4'b0000, 1'b0, 32'h0);

        do_reset();
        repeat (7) cyc(4'b0001, 1'b0, 32'h0);
        check("wd_before", {31'd0, stall_timeout}, 32'd0);
        cyc(4'b0001, 1'b0, 32'h0);
        check("wd_rise", {31'd0, stall_timeout}, 32'd1);
        repeat (3) cyc(4'b0000, 1'b0, 32'h0);
        check("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        do_reset();

        cyc(4'b1000, 1'b1, 32'hCAFE0000);
        cyc(4'b1000, 1'b0, 32'h0);
        do_reset();
        repeat (3) cyc(4'b0000, 1'b0, 32'h0);
        check("midrst_pc", new_pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            r = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 3) == 0) r[3] = stallreq_mem ^ 1'b1;
            else r[3] = stallreq_mem;
            cyc(r, ($urandom_range(0, 7) == 0), $urandom);
        end

        repeat (300) cyc(4'b0100, 1'b0, 32'h0);
        check("cnt_saturate", {24'd0, stall_cycles}, 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
